i2c_byte_engine: RTL and testbench
==================================

I2C_BYTE_ENGINE -- requirements
Module: i2c_byte_engine

Interface
REQ-001 The block SHALL have parameter STRETCH, default 1, meaning "honour slave clock stretching" (1 = on, 0 = ignore SCL_IN).
REQ-002 The block SHALL have port CLK_IN, input, 1 bit: the single system clock; all flops are on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port TICK, input, 1 bit: one-CLK_IN-cycle enable at 4x the SCL rate, from the upstream clock-enable divider.
REQ-005 The block SHALL have port CMD, input, 3 bits: command code; 1=START, 2=STOP, 3=WRITE, 4=READ; all other codes are invalid.
REQ-006 The block SHALL have port CMD_VALID, input, 1 bit: the command request.
REQ-007 The block SHALL have port CMD_READY, output, 1 bit: the block can accept a command.
REQ-008 The block SHALL have port TX_DATA, input, 8 bits: the byte for WRITE.
REQ-009 The block SHALL have port TX_NACK, input, 1 bit: the acknowledge bit driven after READ (0 = ACK, 1 = NACK).
REQ-010 The block SHALL have ports SCL_IN and SDA_IN, input, 1 bit each: the sampled bus levels.
REQ-011 The block SHALL have ports SCL_OE and SDA_OE, output, 1 bit each: open-drain controls (1 = pull low, 0 = release).
REQ-012 The block SHALL have port RX_DATA, output, 8 bits: the byte received by READ.
REQ-013 The block SHALL have port RX_ACK, output, 1 bit: the acknowledge bit sampled after WRITE (0 = ACK).
REQ-014 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse at command completion.
REQ-015 The block SHALL have port BUSY, output, 1 bit: high while a command is executing.

Function
REQ-016 States SHALL be IDLE, START, STOP, WRITE, READ, with a 2-bit phase counter (0..3) and a 4-bit bit counter (0..8).
REQ-017 A command SHALL be accepted on a cycle with CMD_VALID=1, CMD_READY=1 and a valid CMD.
- CMD_READY = 1 only in IDLE; BUSY = ~CMD_READY.
- TX_DATA and TX_NACK are captured at acceptance.
- The phase and bit counters clear to 0.
REQ-018 Invalid CMD codes SHALL be ignored: the block stays in IDLE and DONE is not asserted.
REQ-019 The phase SHALL advance only on cycles with TICK=1 in a non-IDLE state; a TICK on the acceptance cycle SHALL NOT advance the phase.
REQ-020 STOP SHALL drive the bus per phase as follows.
- Phase 0: SCL low, SDA low.
- Phase 1: SCL released.
- Phase 2: SDA released.
- Phase 3: both released.
REQ-021 START SHALL drive the bus per phase as follows.
- Phases 0-1: both released.
- Phase 2: SDA low.
- Phase 3: SCL low, SDA low.
REQ-022 Each WRITE/READ bit SHALL follow this phase sequence.
- Phase 0: SCL low, SDA set to the bit.
- Phase 1: SCL released.
- Phase 2: SCL released, SDA_IN sampled.
- Phase 3: SCL low.
REQ-023 WRITE SHALL run 9 bits.
- Bits 0-7: TX_DATA, MSB first; SDA_OE = ~bit.
- Bit 8: SDA released; SDA_IN sampled into RX_ACK at phase 2.
REQ-024 READ SHALL run 9 bits.
- Bits 0-7: SDA released; SDA_IN shifted in MSB first.
- Bit 8: SDA_OE = ~TX_NACK.
- RX_DATA is updated only on the DONE cycle.
REQ-025 With STRETCH=1, a TICK in phase 1 while SCL_IN=0 SHALL be ignored, holding the phase until SCL_IN=1.
- With STRETCH=0, SCL_IN is ignored.
REQ-026 On the TICK ending phase 3 of the final bit, the block SHALL make three changes on the same edge.
- DONE = 1 for exactly one cycle.
- Return to IDLE.
- CMD_READY = 1 from the next cycle.
REQ-027 Latency from acceptance to DONE SHALL be 4 TICKs for START/STOP and 36 TICKs for WRITE/READ, with no stretching.
REQ-028 In IDLE, SCL_OE and SDA_OE SHALL hold their last values: after STOP both are 0; after START, WRITE or READ, SCL_OE = 1.
REQ-029 After READ and WRITE, SDA_OE SHALL be left at 1.
REQ-030 CMD_VALID while BUSY SHALL be ignored, with no queuing.

Reset
REQ-031 RST=1 SHALL produce the following state on the next CLK_IN edge, regardless of state or TICK.
- State IDLE; phase and bit counters 0.
- SCL_OE=0, SDA_OE=0.
- CMD_READY=1, BUSY=0, DONE=0.
- RX_DATA=0x00, RX_ACK=0.
REQ-032 Reset mid-command SHALL abort without DONE; bus recovery (START/STOP) is the upstream controller's responsibility.

Verification
REQ-033 Reset then idle: RST high 2 cycles -> SCL_OE=0, SDA_OE=0, CMD_READY=1, DONE=0, RX_DATA=0x00.
REQ-034 START then STOP, TICK every 4 cycles: SDA_OE rises while SCL_OE=0 (START), SDA_OE falls while SCL_OE=0 (STOP), one DONE per command, each 4 TICKs after acceptance.
REQ-035 WRITE 0xA5 with SDA_IN=0 during bit 8 -> SDA_OE sequence 0,1,0,1,1,0,1,0 at bits 0-7, RX_ACK=0, DONE after 36 TICKs.
REQ-036 READ with the slave driving 0x3C and TX_NACK=1 -> RX_DATA=0x3C at DONE, SDA_OE=0 during bit 8.
REQ-037 STRETCH=1 with SCL_IN held low for 10 TICKs in phase 1 of bit 2 -> phase frozen, DONE 46 TICKs after acceptance; CMD_VALID with CMD=7 -> no acceptance, no DONE.
REQ-038 RST asserted at bit 4 of WRITE -> next edge: IDLE, SCL_OE=0, SDA_OE=0, no DONE.

Source files
------------

// File: rtl/i2c_byte_engine_if.sv
// Command/response and open-drain bus bundle for the I2C byte engine.
// Handshake: a command transfers on a clock edge where cmd_valid and cmd_ready are both high; cmd_ready is high only while idle.
interface i2c_byte_engine_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_nack;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       done;
  logic       busy;
  logic [2:0] fsm_state;

  modport master (
    input  cmd, cmd_valid, tx_data, tx_nack, scl_in, sda_in,
    output cmd_ready, scl_oe, sda_oe, rx_data, rx_ack, done, busy, fsm_state
  );

  modport slave (
    output cmd, cmd_valid, tx_data, tx_nack, scl_in, sda_in,
    input  cmd_ready, scl_oe, sda_oe, rx_data, rx_ack, done, busy, fsm_state
  );
endinterface

// File: rtl/i2c_byte_engine.sv
// I2C master bit engine: START, STOP, byte WRITE and byte READ, four TICK phases per SCL bit.
// Open-drain enables are registered so they hold their last level while idle.
module i2c_byte_engine #(
  parameter bit STRETCH = 1'b1
) (
  input logic          clk_in,
  input logic          rst,
  input logic          tick,
  i2c_byte_engine_if.master bus
);

  // Encoding matches the command codes so acceptance is a direct cast.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_STOP  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] phase, phase_nxt;
  logic [3:0] bit_cnt, bit_nxt;
  logic [7:0] tx_q, rx_shift, rx_q;
  logic       nack_q, rx_ack_q, done_q, done_nxt;
  logic       scl_q, sda_q, scl_nxt, sda_nxt;
  logic       cmd_ok, accept, advance, final_bit, ending;
  logic [7:0] tx_cur;
  logic       nack_cur, tx_bit;

  assign cmd_ok    = (bus.cmd >= 3'd1) && (bus.cmd <= 3'd4);
  assign accept    = (state == S_IDLE) && bus.cmd_valid && cmd_ok;
  // A released SCL still read low means the slave is stretching the clock.
  assign advance   = (state != S_IDLE) && tick &&
                     !(STRETCH && (phase == 2'd1) && !bus.scl_in);
  assign final_bit = (state == S_START) || (state == S_STOP) || (bit_cnt == 4'd8);
  assign ending    = advance && (phase == 2'd3) && final_bit;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= 2'd0;
      bit_cnt <= 4'd0;
      done_q  <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_cnt <= bit_nxt;
      done_q  <= done_nxt;
      scl_q   <= scl_nxt;
      sda_q   <= sda_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_nxt   = bit_cnt;
    done_nxt  = 1'b0;
    if (accept) begin
      state_nxt = state_t'(bus.cmd);
      phase_nxt = 2'd0;
      bit_nxt   = 4'd0;
    end else if (advance) begin
      if (phase == 2'd3) begin
        phase_nxt = 2'd0;
        if (final_bit) begin
          state_nxt = S_IDLE;
          bit_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          bit_nxt = bit_cnt + 4'd1;
        end
      end else begin
        phase_nxt = phase + 2'd1;
      end
    end
  end

  // Bus levels are computed for the upcoming state/phase and then registered.
  always_comb begin
    tx_cur   = accept ? bus.tx_data : tx_q;
    nack_cur = accept ? bus.tx_nack : nack_q;
    tx_bit   = tx_cur[3'(4'd7 - bit_nxt)];
    scl_nxt  = scl_q;
    sda_nxt  = sda_q;
    case (state_nxt)
      S_IDLE: begin
        // Data commands finish with both lines held low, ready for a STOP or repeated START.
        if ((state == S_WRITE) || (state == S_READ)) begin
          scl_nxt = 1'b1;
          sda_nxt = 1'b1;
        end
      end
      S_START: begin
        scl_nxt = (phase_nxt == 2'd3);
        sda_nxt = phase_nxt[1];
      end
      S_STOP: begin
        scl_nxt = (phase_nxt == 2'd0);
        sda_nxt = !phase_nxt[1];
      end
      S_WRITE: begin
        scl_nxt = (phase_nxt == 2'd0) || (phase_nxt == 2'd3);
        sda_nxt = (bit_nxt < 4'd8) ? ~tx_bit : 1'b0;
      end
      S_READ: begin
        scl_nxt = (phase_nxt == 2'd0) || (phase_nxt == 2'd3);
        sda_nxt = (bit_nxt == 4'd8) ? ~nack_cur : 1'b0;
      end
      default: begin
        scl_nxt = scl_q;
        sda_nxt = sda_q;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tx_q     <= 8'h00;
      nack_q   <= 1'b0;
      rx_shift <= 8'h00;
      rx_q     <= 8'h00;
      rx_ack_q <= 1'b0;
    end else begin
      if (accept) begin
        tx_q   <= bus.tx_data;
        nack_q <= bus.tx_nack;
      end
      if (advance && (phase == 2'd2)) begin
        if ((state == S_WRITE) && (bit_cnt == 4'd8))
          rx_ack_q <= bus.sda_in;
        if ((state == S_READ) && (bit_cnt < 4'd8))
          rx_shift <= {rx_shift[6:0], bus.sda_in};
      end
      if (ending && (state == S_READ))
        rx_q <= rx_shift;
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.scl_oe    = scl_q;
  assign bus.sda_oe    = sda_q;
  assign bus.rx_data   = rx_q;
  assign bus.rx_ack    = rx_ack_q;
  assign bus.done      = done_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine: START/STOP framing, WRITE/READ bytes, stretching, invalid commands, reset abort.
// A small slave model answers on the bus; DONE latencies go through an expected queue.
module tb_i2c_byte_engine;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  always #5 clk = ~clk;

  i2c_byte_engine_if bus ();

  i2c_byte_engine #(.STRETCH(1'b1)) dut (
    .clk_in (clk),
    .rst    (rst),
    .tick   (tick),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int tcnt = 0;
  int tick_count = 0;
  int done_total = 0;
  int rel_count = 0;
  int stretch_left = 0;
  int slave_mode = 0;
  logic [7:0] exp_q[$];
  logic [8:0] rel_sda;
  logic [7:0] rx_at_bit8;
  logic [7:0] slave_byte;
  logic slave_ack;
  logic stretch_arm;
  logic start_seen, stop_seen;
  logic prev_scl, prev_sda;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive TICK, take the edge, sample at the falling edge, update the slave model.
  task automatic step();
    logic edge_tick;
    logic drive;
    int idx;
    tick = (tcnt == 3);
    tcnt = (tcnt + 1) % 4;
    @(posedge clk);
    edge_tick = tick;
    @(negedge clk);
    if (edge_tick) tick_count++;
    if (bus.done) done_total++;
    if (edge_tick && stretch_left > 0) stretch_left--;
    if (!prev_scl && !bus.scl_oe && !prev_sda && bus.sda_oe) start_seen = 1'b1;
    if (!prev_scl && !bus.scl_oe && prev_sda && !bus.sda_oe) stop_seen = 1'b1;
    if (prev_scl && !bus.scl_oe) begin
      if (rel_count < 9) rel_sda[rel_count] = bus.sda_oe;
      if (rel_count == 8) rx_at_bit8 = bus.rx_data;
      rel_count++;
      if (stretch_arm && rel_count == 3) begin
        stretch_left = 10;
        stretch_arm = 1'b0;
      end
    end
    prev_scl = bus.scl_oe;
    prev_sda = bus.sda_oe;
    idx = bus.scl_oe ? rel_count : rel_count - 1;
    drive = 1'b1;
    if (slave_mode == 2 && idx >= 0 && idx < 8) drive = slave_byte[7 - idx];
    if (slave_mode == 1 && idx == 8) drive = slave_ack;
    bus.sda_in = ~bus.sda_oe & drive;
    bus.scl_in = ~bus.scl_oe & (stretch_left == 0);
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] c, input logic [7:0] d,
                         input logic n, input int budget, input logic inject);
    int t0, lat, cyc;
    logic got;
    logic [7:0] exp_lat;
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    bus.tx_data = d;
    bus.tx_nack = n;
    rel_count = 0;
    rel_sda = '0;
    start_seen = 1'b0;
    stop_seen = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    bus.tx_data = ~d;
    bus.tx_nack = ~n;
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
    t0 = tick_count;
    got = 1'b0;
    lat = 0;
    cyc = 0;
    while (!got && cyc < budget) begin
      if (inject) begin
        bus.cmd = 3'd2;
        bus.cmd_valid = (cyc >= 2 && cyc <= 6);
      end
      step();
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        lat = tick_count - t0;
      end
    end
    bus.cmd_valid = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    exp_lat = exp_q.pop_front();
    if (got) check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    step();
    check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int d0, cyc;
    rst = 1'b1;
    tick = 1'b0;
    bus.cmd = 3'd0;
    bus.cmd_valid = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_nack = 1'b0;
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    slave_byte = 8'h00;
    slave_ack = 1'b0;
    stretch_arm = 1'b0;
    rel_sda = '0;
    rx_at_bit8 = 8'hxx;
    prev_scl = 1'b0;
    prev_sda = 1'b0;
    start_seen = 1'b0;
    stop_seen = 1'b0;

    step();
    step();
    check_eq("rst_scl_oe", 32'(bus.scl_oe), 32'd0);
    check_eq("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check_eq("rst_rx_ack", 32'(bus.rx_ack), 32'd0);
    rst = 1'b0;
    step();

    exp_q.push_back(8'd4);
    run_cmd("start", 3'd1, 8'h00, 1'b0, 100, 1'b0);
    check_eq("start_edge", 32'(start_seen), 32'd1);
    check_eq("start_idle_scl", 32'(bus.scl_oe), 32'd1);
    check_eq("start_idle_sda", 32'(bus.sda_oe), 32'd1);

    exp_q.push_back(8'd4);
    run_cmd("stop", 3'd2, 8'h00, 1'b0, 100, 1'b0);
    check_eq("stop_edge", 32'(stop_seen), 32'd1);
    check_eq("stop_idle_scl", 32'(bus.scl_oe), 32'd0);
    check_eq("stop_idle_sda", 32'(bus.sda_oe), 32'd0);

    exp_q.push_back(8'd4);
    run_cmd("start2", 3'd1, 8'h00, 1'b0, 100, 1'b0);
    slave_mode = 1;
    slave_ack = 1'b0;
    exp_q.push_back(8'd36);
    run_cmd("write_a5", 3'd3, 8'hA5, 1'b0, 300, 1'b0);
    check_eq("write_sda_bits", 32'(rel_sda[7:0]), 32'h5A);
    check_eq("write_ack_release", 32'(rel_sda[8]), 32'd0);
    check_eq("write_rx_ack", 32'(bus.rx_ack), 32'd0);
    check_eq("write_idle_scl", 32'(bus.scl_oe), 32'd1);
    check_eq("write_idle_sda", 32'(bus.sda_oe), 32'd1);

    slave_mode = 2;
    slave_byte = 8'h3C;
    exp_q.push_back(8'd36);
    run_cmd("read_3c", 3'd4, 8'h00, 1'b1, 300, 1'b0);
    check_eq("read_rx_data", 32'(bus.rx_data), 32'h3C);
    check_eq("read_rx_before_done", 32'(rx_at_bit8), 32'h00);
    check_eq("read_nack_sda", 32'(rel_sda[8]), 32'd0);
    check_eq("read_idle_sda", 32'(bus.sda_oe), 32'd1);

    d0 = done_total;
    bus.cmd = 3'd7;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) step();
    bus.cmd_valid = 1'b0;
    check_eq("invalid_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("invalid_no_done", 32'(done_total), 32'(d0));
    check_eq("invalid_scl_hold", 32'(bus.scl_oe), 32'd1);

    slave_mode = 1;
    slave_ack = 1'b1;
    stretch_arm = 1'b1;
    exp_q.push_back(8'd46);
    run_cmd("stretch_write", 3'd3, 8'h00, 1'b0, 400, 1'b0);
    check_eq("stretch_rx_ack", 32'(bus.rx_ack), 32'd1);

    d0 = done_total;
    exp_q.push_back(8'd4);
    run_cmd("busy_ignore", 3'd1, 8'h00, 1'b0, 100, 1'b1);
    for (int i = 0; i < 40; i++) step();
    check_eq("busy_ignore_dones", 32'(done_total - d0), 32'd1);
    check_eq("busy_ignore_scl", 32'(bus.scl_oe), 32'd1);

    slave_mode = 1;
    slave_ack = 1'b0;
    bus.cmd = 3'd3;
    bus.tx_data = 8'hFF;
    bus.cmd_valid = 1'b1;
    rel_count = 0;
    step();
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while (rel_count < 5 && cyc < 200) begin
      step();
      cyc++;
    end
    check_eq("abort_reached_bit4", 32'(rel_count >= 5), 32'd1);
    d0 = done_total;
    rst = 1'b1;
    step();
    check_eq("abort_scl_oe", 32'(bus.scl_oe), 32'd0);
    check_eq("abort_sda_oe", 32'(bus.sda_oe), 32'd0);
    check_eq("abort_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) step();
    check_eq("abort_no_done", 32'(done_total), 32'(d0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
